// File: rtl/div_seq.sv
// div_seq: sequential integer divider (restoring shift-subtract, one quotient
// bit per clock).
//
// Ports:
//   clk_i       single clock, rising edge
//   rst_ni      asynchronous active-low reset
//   start_i     start request, accepted only in IDLE or DONE
//   op_i        00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend_i  dividend, latched with an accepted start
//   divisor_i   divisor, latched with an accepted start
//   busy_o      high in CALC and FIX
//   valid_o     one-cycle pulse in DONE
//   result_o    quotient or remainder; updated only on entry to DONE
//
// state | meaning
// IDLE  | waiting for start_i
// CALC  | first cycle converts operands to magnitudes, then WIDTH iterations
// FIX   | sign correction, special cases, quotient/remainder select
// DONE  | result valid for one cycle; a new start may be accepted here
//
// Latency from the accepting edge to valid_o is WIDTH+2 edges: one
// conversion edge, WIDTH iteration edges and the FIX edge.

module div_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             busy_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] result_o
);

   localparam int CW = $clog2(WIDTH + 2);
   localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(1);
   localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_t;

   state_t            state_q;
   logic [1:0]        op_q;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic [WIDTH-1:0]  divm_q;
   logic [WIDTH-1:0]  quo_q;
   logic [WIDTH:0]    rem_q;
   logic              neg_quo_q;
   logic              neg_rem_q;
   logic [CW-1:0]     cnt_q;

   logic              signed_op;
   logic              a_neg;
   logic              b_neg;
   logic [WIDTH-1:0]  a_mag;
   logic [WIDTH-1:0]  b_mag;
   logic [WIDTH+1:0]  shifted;
   logic [WIDTH+1:0]  diff;
   logic [WIDTH-1:0]  q_fix;
   logic [WIDTH-1:0]  r_fix;
   logic [WIDTH-1:0]  fix_res;

   always_comb begin
      signed_op = ~op_q[0];
      a_neg     = signed_op & a_q[WIDTH-1];
      b_neg     = signed_op & b_q[WIDTH-1];
      a_mag     = a_neg ? -a_q : a_q;
      b_mag     = b_neg ? -b_q : b_q;

      // Partial remainder shifted left with the next dividend bit; one extra
      // top bit makes the subtraction result's sign directly visible.
      shifted   = {rem_q, quo_q[WIDTH-1]};
      diff      = shifted - {2'b00, divm_q};

      q_fix = neg_quo_q ? -quo_q : quo_q;
      r_fix = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
      if (b_q == '0) begin
         q_fix = '1;
         r_fix = a_q;
      end else if (signed_op && (a_q == INT_MIN) && (b_q == '1)) begin
         q_fix = INT_MIN;
         r_fix = '0;
      end
      fix_res = op_q[1] ? r_fix : q_fix;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         divm_q    <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         cnt_q     <= '0;
         busy_o    <= 1'b0;
         valid_o   <= 1'b0;
         result_o  <= '0;
      end else begin
         valid_o <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  op_q    <= op_i;
                  a_q     <= dividend_i;
                  b_q     <= divisor_i;
                  cnt_q   <= CNT_LOAD;
                  busy_o  <= 1'b1;
                  state_q <= S_CALC;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_CALC: begin
               if (cnt_q == CNT_LOAD) begin
                  quo_q     <= a_mag;
                  divm_q    <= b_mag;
                  rem_q     <= '0;
                  neg_quo_q <= a_neg ^ b_neg;
                  neg_rem_q <= a_neg;
               end else begin
                  if (!diff[WIDTH+1]) begin
                     rem_q <= diff[WIDTH:0];
                     quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                  end else begin
                     rem_q <= shifted[WIDTH:0];
                     quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                  end
                  if (cnt_q == CNT_LAST) begin
                     state_q <= S_FIX;
                  end
               end
               cnt_q <= cnt_q - CNT_LAST;
            end
            S_FIX: begin
               result_o <= fix_res;
               valid_o  <= 1'b1;
               busy_o   <= 1'b0;
               state_q  <= S_DONE;
            end
            default: begin
               busy_o  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// Testbench for div_seq: directed operations, expected results pushed into a
// scoreboard when each start is accepted; a negedge monitor pops and checks
// result value and arrival cycle whenever valid_o is seen.

module tb_div_seq;

   localparam int W   = 32;
   localparam int LAT = 34;

   logic          clk_i      = 1'b0;
   logic          rst_ni     = 1'b0;
   logic          start_i    = 1'b0;
   logic [1:0]    op_i       = 2'b00;
   logic [W-1:0]  dividend_i = '0;
   logic [W-1:0]  divisor_i  = '0;
   logic          busy_o;
   logic          valid_o;
   logic [W-1:0]  result_o;

   div_seq #(.WIDTH(W)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .start_i    (start_i),
      .op_i       (op_i),
      .dividend_i (dividend_i),
      .divisor_i  (divisor_i),
      .busy_o     (busy_o),
      .valid_o    (valid_o),
      .result_o   (result_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [W-1:0] res;
      int           due;
   } exp_t;

   exp_t         sb[$];
   exp_t         mon_e;
   logic [W-1:0] last_res = '0;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   always @(negedge clk_i) begin
      if (rst_ni && valid_o) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got valid_o=1 at cycle %0d, expected no pulse", cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("result", result_o, mon_e.res);
            chk("busy_in_done", {31'd0, busy_o}, '0);
            checks++;
            if (cyc != mon_e.due) begin
               errors++;
               $display("FAIL latency: got valid at cycle %0d, expected cycle %0d", cyc, mon_e.due);
            end
         end
      end
   end

   // Called just after a negedge; the following posedge accepts the start.
   task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_res, input bit push);
      start_i    = 1'b1;
      op_i       = op;
      dividend_i = a;
      divisor_i  = b;
      @(posedge clk_i);
      #1;
      if (push) sb.push_back('{exp_res, cyc + LAT});
      start_i = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk_i);
         #1;
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout: got %0d results outstanding, expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic run_one(input string name, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_res);
      @(negedge clk_i);
      issue(op, a, b, exp_res, 1'b1);
      repeat (20) @(negedge clk_i);
      chk({name, "_hold"}, result_o, last_res);
      chk({name, "_busy"}, {31'd0, busy_o}, 32'd1);
      wait_done();
      last_res = exp_res;
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk_i);
      chk("rst_busy", {31'd0, busy_o}, '0);
      chk("rst_valid", {31'd0, valid_o}, '0);
      chk("rst_result", result_o, '0);
      rst_ni = 1'b1;
      repeat (2) @(negedge clk_i);

      run_one("divu_100_7",  OP_DIVU, 32'd100, 32'd7, 32'd14);
      run_one("remu_100_7",  OP_REMU, 32'd100, 32'd7, 32'd2);
      run_one("div_m7_2",    OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      run_one("rem_m7_2",    OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      run_one("div_7_m2",    OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
      run_one("rem_7_m2",    OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1);
      run_one("div_5_0",     OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF);
      run_one("remu_5_0",    OP_REMU, 32'd5, 32'd0, 32'd5);
      run_one("rem_m7_0",    OP_REM,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
      run_one("divu_5_0",    OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
      run_one("div_ovf",     OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      run_one("rem_ovf",     OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
      run_one("divu_min_m1", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
      run_one("remu_min_m1", OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      run_one("divu_max_1",  OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
      run_one("divu_max_max",OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
      run_one("div_m100_7",  OP_DIV,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);

      // Start while busy is ignored; back-to-back start in DONE is accepted.
      @(negedge clk_i);
      issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
      repeat (9) @(negedge clk_i);
      issue(OP_DIVU, 32'd9, 32'd3, 32'd0, 1'b0);
      n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (!valid_o && n < 60);
      checks++;
      if (!valid_o) begin
         errors++;
         $display("FAIL b2b_wait: got no valid_o within %0d cycles, expected a pulse", n);
      end
      issue(OP_REMU, 32'd100, 32'd7, 32'd2, 1'b1);
      wait_done();
      last_res = 32'd2;

      // Reset mid-operation aborts without a valid pulse.
      @(negedge clk_i);
      issue(OP_DIVU, 32'd100, 32'd7, 32'd0, 1'b0);
      repeat (14) @(posedge clk_i);
      #2 rst_ni = 1'b0;
      #1;
      chk("rstmid_busy", {31'd0, busy_o}, '0);
      chk("rstmid_result", result_o, '0);
      chk("rstmid_valid", {31'd0, valid_o}, '0);
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;
      last_res = '0;
      repeat (50) @(negedge clk_i);
      run_one("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3);

      repeat (5) @(negedge clk_i);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
